// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-request instruction fetch unit with branch redirect and flush
module instr_fetch #(
   parameter int                 ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_f,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       ir,
   output logic              ir_valid,
   input  logic              ir_ready,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic [ADDR_W-1:0] pc
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_req_q;
   logic [31:0]       ir_q;
   logic              ir_valid_q;
   // Set when a redirect arrives while a read is still outstanding; the
   // returning word belongs to the old stream and must be dropped.
   logic              flush_q;
   logic [ADDR_W-1:0] pc_inc_d;

   // Sequential successor address; wraps naturally at the top of the space.
   assign pc_inc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   // Fetch FSM: all outputs are registered and updated alongside the state.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         mem_addr_q <= RESET_PC;
         mem_req_q  <= 1'b0;
         ir_q       <= 32'h0;
         ir_valid_q <= 1'b0;
         flush_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q    <= FETCH;
               mem_req_q  <= 1'b1;
               mem_addr_q <= pc_q;
            end
            FETCH: begin
               if (mem_ack) begin
                  if (br_taken) begin
                     // Data and any pending flush are superseded by the new target.
                     pc_q       <= br_target;
                     mem_addr_q <= br_target;
                     flush_q    <= 1'b0;
                  end else if (flush_q) begin
                     // Stale word from before the redirect; reissue at pc.
                     flush_q    <= 1'b0;
                     mem_addr_q <= pc_q;
                  end else begin
                     ir_q       <= mem_rdata;
                     ir_valid_q <= 1'b1;
                     mem_req_q  <= 1'b0;
                     state_q    <= HOLD;
                  end
               end else if (br_taken) begin
                  // Outstanding address stays put until memory answers.
                  pc_q    <= br_target;
                  flush_q <= 1'b1;
               end
            end
            HOLD: begin
               if (br_taken) begin
                  ir_valid_q <= 1'b0;
                  pc_q       <= br_target;
                  mem_addr_q <= br_target;
                  mem_req_q  <= 1'b1;
                  state_q    <= FETCH;
               end else if (ir_ready) begin
                  ir_valid_q <= 1'b0;
                  pc_q       <= pc_inc_d;
                  mem_addr_q <= pc_inc_d;
                  mem_req_q  <= 1'b1;
                  state_q    <= FETCH;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_req  = mem_req_q;
   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign pc       = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed vector bench for instr_fetch
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_f;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] ir;
   logic        ir_valid;
   logic        ir_ready;
   logic        br_taken;
   logic [15:0] br_target;
   logic [15:0] pc;

   int checks = 0;
   int errors = 0;

   instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk       (clk),
      .rst_f     (rst_f),
      .mem_addr  (mem_addr),
      .mem_req   (mem_req),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .ir_ready  (ir_ready),
      .br_taken  (br_taken),
      .br_target (br_target),
      .pc        (pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        br;
      logic [15:0] tgt;
      logic        req;
      logic [15:0] addr;
      logic        v;
      logic [31:0] ir;
      logic [15:0] pc;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic ack, input logic [31:0] rdata, input logic rdy,
                      input logic br, input logic [15:0] tgt, input logic req,
                      input logic [15:0] addr, input logic v, input logic [31:0] irv,
                      input logic [15:0] pcv);
      vec_t t;
      t.ack = ack; t.rdata = rdata; t.rdy = rdy; t.br = br; t.tgt = tgt;
      t.req = req; t.addr = addr; t.v = v; t.ir = irv; t.pc = pcv;
      tv.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic req, input logic [15:0] addr,
                          input logic v, input logic [31:0] irv, input logic [15:0] pcv);
      chk({tag, ".mem_req"},  {31'd0, mem_req},  {31'd0, req});
      chk({tag, ".mem_addr"}, {16'd0, mem_addr}, {16'd0, addr});
      chk({tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, v});
      chk({tag, ".ir"},       ir,                irv);
      chk({tag, ".pc"},       {16'd0, pc},       {16'd0, pcv});
   endtask

   task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                        input logic br, input logic [15:0] tgt);
      mem_ack = ack; mem_rdata = rdata; ir_ready = rdy; br_taken = br; br_target = tgt;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //  ack rdata         rdy br  tgt       req addr      v  ir            pc
      add(1, 32'hEEEE_EEEE, 1, 1, 16'h1234, 1, 16'h0000, 0, 32'h0,        16'h0000); // IDLE ignores ack/br
      add(1, 32'hA000_0000, 1, 0, 16'h0,    0, 16'h0000, 1, 32'hA000_0000, 16'h0000);
      add(0, 32'h0,         1, 0, 16'h0,    1, 16'h0001, 0, 32'hA000_0000, 16'h0001);
      add(1, 32'hA000_0001, 1, 0, 16'h0,    0, 16'h0001, 1, 32'hA000_0001, 16'h0001);
      add(0, 32'h0,         1, 0, 16'h0,    1, 16'h0002, 0, 32'hA000_0001, 16'h0002);
      add(1, 32'hA000_0002, 1, 0, 16'h0,    0, 16'h0002, 1, 32'hA000_0002, 16'h0002);
      add(0, 32'h0,         1, 0, 16'h0,    1, 16'h0003, 0, 32'hA000_0002, 16'h0003);
      add(1, 32'hA000_0003, 0, 0, 16'h0,    0, 16'h0003, 1, 32'hA000_0003, 16'h0003);
      for (int i = 0; i < 5; i++)  // stall in HOLD; ack noise ignored
         add(1, 32'hDEAD_BEEF, 0, 0, 16'h0, 0, 16'h0003, 1, 32'hA000_0003, 16'h0003);
      add(0, 32'h0,         1, 0, 16'h0,    1, 16'h0004, 0, 32'hA000_0003, 16'h0004);
      add(1, 32'hA000_0004, 0, 0, 16'h0,    0, 16'h0004, 1, 32'hA000_0004, 16'h0004);
      add(0, 32'h0,         1, 0, 16'h0,    1, 16'h0005, 0, 32'hA000_0004, 16'h0005);
      add(1, 32'hA000_0005, 0, 0, 16'h0,    0, 16'h0005, 1, 32'hA000_0005, 16'h0005);
      add(0, 32'h0,         0, 1, 16'h0040, 1, 16'h0040, 0, 32'hA000_0005, 16'h0040); // branch in HOLD
      add(1, 32'hB000_0000, 0, 0, 16'h0,    0, 16'h0040, 1, 32'hB000_0000, 16'h0040);
      add(0, 32'h0,         1, 1, 16'h0060, 1, 16'h0060, 0, 32'hB000_0000, 16'h0060); // branch + consume
      add(1, 32'hB000_0001, 0, 0, 16'h0,    0, 16'h0060, 1, 32'hB000_0001, 16'h0060);
      add(0, 32'h0,         1, 0, 16'h0,    1, 16'h0061, 0, 32'hB000_0001, 16'h0061);
      add(0, 32'h0,         0, 1, 16'h0080, 1, 16'h0061, 0, 32'hB000_0001, 16'h0080); // flush pending
      add(0, 32'h0,         0, 0, 16'h0,    1, 16'h0061, 0, 32'hB000_0001, 16'h0080);
      add(0, 32'h0,         0, 0, 16'h0,    1, 16'h0061, 0, 32'hB000_0001, 16'h0080);
      add(1, 32'hBAD0_0000, 0, 0, 16'h0,    1, 16'h0080, 0, 32'hB000_0001, 16'h0080); // discarded
      add(1, 32'hC000_0000, 0, 0, 16'h0,    0, 16'h0080, 1, 32'hC000_0000, 16'h0080);
      add(0, 32'h0,         1, 0, 16'h0,    1, 16'h0081, 0, 32'hC000_0000, 16'h0081);
      add(0, 32'h0,         0, 1, 16'h0100, 1, 16'h0081, 0, 32'hC000_0000, 16'h0100);
      add(0, 32'h0,         0, 1, 16'h0200, 1, 16'h0081, 0, 32'hC000_0000, 16'h0200); // last wins
      add(1, 32'hBAD0_0001, 0, 0, 16'h0,    1, 16'h0200, 0, 32'hC000_0000, 16'h0200);
      add(1, 32'hBAD0_0002, 0, 1, 16'hFFFF, 1, 16'hFFFF, 0, 32'hC000_0000, 16'hFFFF); // br with ack
      add(1, 32'hC000_0001, 0, 0, 16'h0,    0, 16'hFFFF, 1, 32'hC000_0001, 16'hFFFF);
      add(0, 32'h0,         1, 0, 16'h0,    1, 16'h0000, 0, 32'hC000_0001, 16'h0000); // wrap
      add(1, 32'hC000_0002, 0, 0, 16'h0,    0, 16'h0000, 1, 32'hC000_0002, 16'h0000);

      rst_f = 1'b0;
      drive(0, 32'h0, 0, 0, 16'h0);
      #2;
      chk_all("reset", 0, 16'h0000, 0, 32'h0, 16'h0000);
      @(posedge clk); @(posedge clk); #1;
      chk_all("reset_held", 0, 16'h0000, 0, 32'h0, 16'h0000);
      rst_f = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].ack, tv[i].rdata, tv[i].rdy, tv[i].br, tv[i].tgt);
         @(posedge clk); #1;
         chk_all($sformatf("v%0d", i), tv[i].req, tv[i].addr, tv[i].v, tv[i].ir, tv[i].pc);
      end

      // Async reset mid-HOLD: outputs drop before the next edge.
      drive(0, 32'h0, 0, 0, 16'h0);
      #2 rst_f = 1'b0;
      #1 chk_all("arst_hold", 0, 16'h0000, 0, 32'h0, 16'h0000);
      @(posedge clk); #1;
      rst_f = 1'b1;
      drive(1, 32'hEEEE_0000, 1, 1, 16'h1234);
      @(posedge clk); #1;
      chk_all("restart1", 1, 16'h0000, 0, 32'h0, 16'h0000);
      drive(1, 32'hD000_0000, 0, 0, 16'h0);
      @(posedge clk); #1;
      chk_all("restart1_hold", 0, 16'h0000, 1, 32'hD000_0000, 16'h0000);
      drive(0, 32'h0, 1, 0, 16'h0);
      @(posedge clk); #1;
      chk_all("fetch1", 1, 16'h0001, 0, 32'hD000_0000, 16'h0001);

      // Async reset mid-FETCH with a read outstanding.
      drive(0, 32'h0, 0, 0, 16'h0);
      #2 rst_f = 1'b0;
      #1 chk_all("arst_fetch", 0, 16'h0000, 0, 32'h0, 16'h0000);
      @(posedge clk); #1;
      rst_f = 1'b1;
      drive(1, 32'hEEEE_0001, 0, 0, 16'h0);
      @(posedge clk); #1;
      chk_all("restart2", 1, 16'h0000, 0, 32'h0, 16'h0000);
      drive(1, 32'hD000_0001, 0, 0, 16'h0);
      @(posedge clk); #1;
      chk_all("restart2_hold", 0, 16'h0000, 1, 32'hD000_0001, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
